// File: rtl/sort_result_reader.sv
// Streams the sorted array out of the bubble-sort RAM after eoc, absorbing the 1-cycle RAM
// read latency in a 2-entry skid FIFO and flagging any out-of-order word seen by the consumer.
module sort_result_reader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int N_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              eoc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              order_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] slot0_data_q, slot0_data_d, slot1_data_q, slot1_data_d;
    logic              slot0_last_q, slot0_last_d, slot1_last_q, slot1_last_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              first_q, first_d;
    logic              order_err_q, order_err_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic is_last_addr, abort, pop, push, last_xfer;

    // Handshake: a word moves when out_valid & out_ready at a rising edge; out_valid never
    // depends on out_ready, and the head entry is held unchanged while stalled.
    assign out_valid    = (count_q != 2'd0);
    assign out_data     = slot0_data_q;
    assign out_last     = slot0_last_q & out_valid;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign order_err    = order_err_q;
    assign mem_addr     = rd_cnt_q;
    assign dbg_state    = state_q;

    assign is_last_addr = (rd_cnt_q == ADDR_W'(N_WORDS - 1));
    assign abort        = busy & ~eoc;
    // Issue only when the read is guaranteed a FIFO slot when its data returns.
    assign mem_rd       = (state_q == READ) &&
                          (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
    assign pop          = out_valid & out_ready & ~abort;
    assign push         = inflight_q & ~abort;
    assign last_xfer    = pop & slot0_last_q;

    always_comb begin
        state_d         = state_q;
        rd_cnt_d        = rd_cnt_q;
        inflight_d      = mem_rd & ~abort;
        inflight_last_d = mem_rd & is_last_addr;
        count_d         = count_q;
        slot0_data_d    = slot0_data_q;
        slot0_last_d    = slot0_last_q;
        slot1_data_d    = slot1_data_q;
        slot1_last_d    = slot1_last_q;
        prev_d          = prev_q;
        first_d         = first_q;
        order_err_d     = order_err_q;
        done_d          = last_xfer;
        aborted_d       = abort;

        case (state_q)
            IDLE:    if (start && eoc) state_d = READ;
            READ:    if (abort) state_d = IDLE;
                     else if (mem_rd && is_last_addr) state_d = DRAIN;
            DRAIN:   if (abort || last_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            rd_cnt_d = '0;
        end else if (mem_rd && !is_last_addr) begin
            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
        end

        if (abort) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                slot0_data_d = slot1_data_q;
                slot0_last_d = slot1_last_q;
            end
            if (push) begin
                if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                    slot0_data_d = mem_rdata;
                    slot0_last_d = inflight_last_q;
                end else begin
                    slot1_data_d = mem_rdata;
                    slot1_last_d = inflight_last_q;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end

        if (state_q == IDLE && state_d == READ) begin
            order_err_d = 1'b0;
            prev_d      = '0;
            first_d     = 1'b1;
        end else if (pop) begin
            if (!first_q && out_data < prev_q) order_err_d = 1'b1;
            prev_d  = out_data;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            slot0_data_q    <= '0;
            slot0_last_q    <= 1'b0;
            slot1_data_q    <= '0;
            slot1_last_q    <= 1'b0;
            prev_q          <= '0;
            first_q         <= 1'b1;
            order_err_q     <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            slot0_data_q    <= slot0_data_d;
            slot0_last_q    <= slot0_last_d;
            slot1_data_q    <= slot1_data_d;
            slot1_last_q    <= slot1_last_d;
            prev_q          <= prev_d;
            first_q         <= first_d;
            order_err_q     <= order_err_d;
            done_q          <= done_d;
            aborted_q       <= aborted_d;
        end
    end

endmodule
